// File: rtl/geofence_feeder_if.sv
// Point-stream bundle shared by the host write port, the engine X/Y bus and the
// result return path. The feeder sits on the slave side. The host and the
// engine (or a bench standing in for both) sit on the master side.
interface geofence_feeder_if;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_x;
    logic [9:0] in_y;

    logic [9:0] gf_x;
    logic [9:0] gf_y;
    logic       gf_valid;
    logic       gf_is_inside;

    logic       res_valid;
    logic       res_inside;
    logic [7:0] res_tag;

    modport slave (
        input  in_valid, in_x, in_y, gf_valid, gf_is_inside,
        output in_ready, gf_x, gf_y, res_valid, res_inside, res_tag
    );

    modport master (
        output in_valid, in_x, in_y, gf_valid, gf_is_inside,
        input  in_ready, gf_x, gf_y, res_valid, res_inside, res_tag
    );
endinterface

// File: rtl/geofence_feeder.sv
// Geofence engine feeder. It buffers 7-point frames written by the host and
// streams one frame per engine round onto the engine's X/Y bus. It returns the
// engine's verdict to the host, tagged with the frame ordinal. The engine never
// stalls, so a zero filler frame goes out whenever no complete frame is buffered.
module geofence_feeder #(
    parameter int FRAME_DEPTH = 2,
    parameter int TIMEOUT     = 32
) (
    input  logic                clk,
    input  logic                reset,
    geofence_feeder_if.slave    bus,
    output logic [7:0]          filler_cnt,
    output logic                err
);

    localparam int PTS     = 7;
    localparam int ENTRIES = FRAME_DEPTH * PTS;
    localparam int SLOT_W  = (FRAME_DEPTH > 1) ? $clog2(FRAME_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FRAME_DEPTH + 1);
    localparam int ADDR_W  = $clog2(ENTRIES);
    localparam int WAIT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic {
        ST_SEND,
        ST_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               real_q, real_d;

    logic [19:0]        mem_q [ENTRIES];
    logic [19:0]        mem_d [ENTRIES];
    logic [SLOT_W-1:0]  wr_slot_q, wr_slot_d;
    logic [SLOT_W-1:0]  rd_slot_q, rd_slot_d;
    logic [2:0]         wr_pt_q, wr_pt_d;
    logic [CNT_W-1:0]   cnt_full_q, cnt_full_d;

    logic [7:0]         tag_q, tag_d;
    logic [7:0]         filler_q, filler_d;
    logic               err_q, err_d;
    logic               res_valid_q, res_valid_d;
    logic               res_inside_q, res_inside_d;
    logic [7:0]         res_tag_q, res_tag_d;

    logic               wr_fire;
    logic               wr_frame_done;
    logic               rd_frame_done;
    logic               frame_real;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ADDR_W-1:0]  rd_addr;
    logic [9:0]         gf_x_c;
    logic [9:0]         gf_y_c;

    function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
        if (s == SLOT_W'(FRAME_DEPTH - 1)) begin
            return '0;
        end
        return s + SLOT_W'(1);
    endfunction

    // Write side: accept host points into the current slot and track how many complete frames are buffered.
    always_comb begin
        wr_fire       = bus.in_valid && bus.in_ready;
        wr_frame_done = wr_fire && (wr_pt_q == 3'd6);
        wr_addr       = ADDR_W'(wr_slot_q) * ADDR_W'(PTS) + ADDR_W'(wr_pt_q);
        wr_slot_d     = wr_slot_q;
        wr_pt_d       = wr_pt_q;
        cnt_full_d    = cnt_full_q;
        for (int i = 0; i < ENTRIES; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_fire) begin
            mem_d[wr_addr] = {bus.in_x, bus.in_y};
            if (wr_pt_q == 3'd6) begin
                wr_pt_d   = 3'd0;
                wr_slot_d = next_slot(wr_slot_q);
            end else begin
                wr_pt_d = wr_pt_q + 3'd1;
            end
        end
        // A frame landing in the same cycle one leaves keeps the count steady.
        case ({wr_frame_done, rd_frame_done})
            2'b10:   cnt_full_d = cnt_full_q + CNT_W'(1);
            2'b01:   cnt_full_d = cnt_full_q - CNT_W'(1);
            default: cnt_full_d = cnt_full_q;
        endcase
    end

    // Frame sequencer: stream 7 points in lock-step with the engine, then wait for its verdict or time out.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        wait_d        = wait_q;
        real_d        = real_q;
        rd_slot_d     = rd_slot_q;
        tag_d         = tag_q;
        filler_d      = filler_q;
        err_d         = err_q;
        res_valid_d   = 1'b0;
        res_inside_d  = res_inside_q;
        res_tag_d     = res_tag_q;
        rd_frame_done = 1'b0;
        frame_real    = 1'b0;
        rd_addr       = ADDR_W'(rd_slot_q) * ADDR_W'(PTS) + ADDR_W'(idx_q);
        gf_x_c        = 10'd0;
        gf_y_c        = 10'd0;
        case (state_q)
            ST_SEND: begin
                // The real/filler choice is made from the buffered count at idx 0 and then held.
                frame_real = (idx_q == 3'd0) ? (cnt_full_q != '0) : real_q;
                if (frame_real) begin
                    {gf_x_c, gf_y_c} = mem_q[rd_addr];
                end
                if (idx_q == 3'd0) begin
                    real_d = frame_real;
                    if (!frame_real && (filler_q != 8'hFF)) begin
                        filler_d = filler_q + 8'd1;
                    end
                end
                if (bus.gf_valid) begin
                    err_d = 1'b1;
                end
                if (idx_q == 3'd6) begin
                    rd_frame_done = frame_real;
                    if (frame_real) begin
                        rd_slot_d = next_slot(rd_slot_q);
                    end
                    idx_d   = 3'd0;
                    wait_d  = '0;
                    state_d = ST_WAIT;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            ST_WAIT: begin
                if (bus.gf_valid) begin
                    if (real_q) begin
                        res_valid_d  = 1'b1;
                        res_inside_d = bus.gf_is_inside;
                        res_tag_d    = tag_q;
                        tag_d        = tag_q + 8'd1;
                    end
                    idx_d   = 3'd0;
                    state_d = ST_SEND;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    // The engine missed its slot. Burn the tag so later ordinals still match host frames.
                    err_d = 1'b1;
                    if (real_q) begin
                        tag_d = tag_q + 8'd1;
                    end
                    idx_d   = 3'd0;
                    state_d = ST_SEND;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = ST_SEND;
                idx_d   = 3'd0;
            end
        endcase
    end

    // State register. Reset discards the buffer by clearing every pointer and count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_SEND;
            idx_q        <= 3'd0;
            wait_q       <= '0;
            real_q       <= 1'b0;
            wr_slot_q    <= '0;
            rd_slot_q    <= '0;
            wr_pt_q      <= 3'd0;
            cnt_full_q   <= '0;
            tag_q        <= 8'd0;
            filler_q     <= 8'd0;
            err_q        <= 1'b0;
            res_valid_q  <= 1'b0;
            res_inside_q <= 1'b0;
            res_tag_q    <= 8'd0;
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= 20'd0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wait_q       <= wait_d;
            real_q       <= real_d;
            wr_slot_q    <= wr_slot_d;
            rd_slot_q    <= rd_slot_d;
            wr_pt_q      <= wr_pt_d;
            cnt_full_q   <= cnt_full_d;
            tag_q        <= tag_d;
            filler_q     <= filler_d;
            err_q        <= err_d;
            res_valid_q  <= res_valid_d;
            res_inside_q <= res_inside_d;
            res_tag_q    <= res_tag_d;
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.in_ready   = (cnt_full_q < CNT_W'(FRAME_DEPTH));
    assign bus.gf_x       = gf_x_c;
    assign bus.gf_y       = gf_y_c;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_inside = res_inside_q;
    assign bus.res_tag    = res_tag_q;
    assign filler_cnt     = filler_q;
    assign err            = err_q;

endmodule

// File: tb/tb_geofence_feeder.sv
// Directed bench for geofence_feeder. A small engine stand-in runs a fixed
// 25-cycle round: it samples 7 points, raises gf_valid 18 cycles after the
// last point, and answers with a bounding-box inside test.
module tb_geofence_feeder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] filler_cnt;
    logic       err;

    geofence_feeder_if bus ();

    geofence_feeder #(
        .FRAME_DEPTH (2),
        .TIMEOUT     (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .filler_cnt (filler_cnt),
        .err        (err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          res_seen = 0;
    int          gf_nonzero = 0;
    logic [19:0] host_q [$];

    logic [4:0]  phase;
    logic [9:0]  cap_x [7];
    logic [9:0]  cap_y [7];
    logic        inside_q;
    logic        engine_on = 1'b1;
    logic        inject = 1'b0;

    logic [19:0] f0_pts [7];
    logic [19:0] f1_pts [7];

    function automatic logic in_box();
        logic [9:0] xmin, xmax, ymin, ymax;
        xmin = cap_x[1]; xmax = cap_x[1];
        ymin = cap_y[1]; ymax = cap_y[1];
        for (int i = 2; i < 7; i++) begin
            if (cap_x[i] < xmin) xmin = cap_x[i];
            if (cap_x[i] > xmax) xmax = cap_x[i];
            if (cap_y[i] < ymin) ymin = cap_y[i];
            if (cap_y[i] > ymax) ymax = cap_y[i];
        end
        return (cap_x[0] >= xmin) && (cap_x[0] <= xmax) && (cap_y[0] >= ymin) && (cap_y[0] <= ymax);
    endfunction

    // Engine stand-in: it samples points in phases 0..6, evaluates in phase 7, and strobes in phase 24.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            phase    <= 5'd0;
            inside_q <= 1'b0;
        end else begin
            phase <= (phase == 5'd24) ? 5'd0 : phase + 5'd1;
            if (phase < 5'd7) begin
                cap_x[phase[2:0]] <= bus.gf_x;
                cap_y[phase[2:0]] <= bus.gf_y;
            end
            if (phase == 5'd7) begin
                inside_q <= in_box();
            end
        end
    end

    assign bus.gf_valid     = (engine_on && (phase == 5'd24)) || inject;
    assign bus.gf_is_inside = inside_q;

    task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", name, observed, expected);
        end
    endtask

    // One clock cycle: present the head of the host queue, then pop it if it was accepted.
    task automatic applyStimulus();
        logic accept;
        if (host_q.size() > 0) begin
            bus.in_valid = 1'b1;
            bus.in_x     = host_q[0][19:10];
            bus.in_y     = host_q[0][9:0];
        end else begin
            bus.in_valid = 1'b0;
            bus.in_x     = 10'd0;
            bus.in_y     = 10'd0;
        end
        accept = bus.in_valid && bus.in_ready;
        @(negedge clk);
        if (accept) void'(host_q.pop_front());
        cyc++;
        if (bus.res_valid) res_seen++;
        if ((bus.gf_x != 10'd0) || (bus.gf_y != 10'd0)) gf_nonzero++;
    endtask

    task automatic runTo(input int target);
        while (cyc < target) applyStimulus();
    endtask

    task automatic pushFrame(input logic [9:0] dx, input logic [9:0] dy);
        host_q.push_back({dx, dy});
        host_q.push_back({10'd200, 10'd300});
        host_q.push_back({10'd250, 10'd213});
        host_q.push_back({10'd350, 10'd213});
        host_q.push_back({10'd400, 10'd300});
        host_q.push_back({10'd350, 10'd387});
        host_q.push_back({10'd250, 10'd387});
    endtask

    task automatic releaseReset();
        reset      = 1'b0;
        cyc        = 0;
        res_seen   = 0;
        gf_nonzero = 0;
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, "_res_valid"},  32'(bus.res_valid),  32'd0);
        checkOutput({name, "_res_inside"}, 32'(bus.res_inside), 32'd0);
        checkOutput({name, "_res_tag"},    32'(bus.res_tag),    32'd0);
        checkOutput({name, "_filler"},     32'(filler_cnt),     32'd0);
        checkOutput({name, "_err"},        32'(err),            32'd0);
        checkOutput({name, "_in_ready"},   32'(bus.in_ready),   32'd1);
        checkOutput({name, "_gf_x"},       32'(bus.gf_x),       32'd0);
        checkOutput({name, "_gf_y"},       32'(bus.gf_y),       32'd0);
    endtask

    task automatic doReset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_x     = 10'd0;
        bus.in_y     = 10'd0;
        inject       = 1'b0;
        host_q.delete();
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        releaseReset();
    endtask

    // Directed sequence of scenarios.
    initial begin
        f0_pts = '{{10'd300, 10'd300}, {10'd200, 10'd300}, {10'd250, 10'd213}, {10'd350, 10'd213},
                   {10'd400, 10'd300}, {10'd350, 10'd387}, {10'd250, 10'd387}};
        f1_pts = '{{10'd600, 10'd600}, {10'd200, 10'd300}, {10'd250, 10'd213}, {10'd350, 10'd213},
                   {10'd400, 10'd300}, {10'd350, 10'd387}, {10'd250, 10'd387}};

        // Inside, outside and backpressure on one stream of three frames.
        $display("[TB] three-frame stream");
        doReset();
        pushFrame(10'd300, 10'd300);
        pushFrame(10'd600, 10'd600);
        pushFrame(10'd300, 10'd250);
        runTo(1);
        checkOutput("first_filler", 32'(filler_cnt), 32'd1);
        runTo(3);
        checkOutput("filler_gf_x", 32'(bus.gf_x), 32'd0);
        runTo(13);
        checkOutput("ready_before_full", 32'(bus.in_ready), 32'd1);
        runTo(14);
        checkOutput("ready_full", 32'(bus.in_ready), 32'd0);
        runTo(24);
        checkOutput("wait_gf_x", 32'(bus.gf_x), 32'd0);
        for (int k = 0; k < 7; k++) begin
            runTo(25 + k);
            checkOutput($sformatf("f0_x%0d", k), 32'(bus.gf_x), 32'(f0_pts[k][19:10]));
            checkOutput($sformatf("f0_y%0d", k), 32'(bus.gf_y), 32'(f0_pts[k][9:0]));
        end
        checkOutput("ready_at_idx6", 32'(bus.in_ready), 32'd0);
        runTo(32);
        checkOutput("ready_after_idx6", 32'(bus.in_ready), 32'd1);
        runTo(49);
        checkOutput("res0_early", 32'(bus.res_valid), 32'd0);
        runTo(50);
        checkOutput("res0_valid",  32'(bus.res_valid),  32'd1);
        checkOutput("res0_inside", 32'(bus.res_inside), 32'd1);
        checkOutput("res0_tag",    32'(bus.res_tag),    32'd0);
        checkOutput("f1_x0",       32'(bus.gf_x),       32'(f1_pts[0][19:10]));
        checkOutput("f1_y0",       32'(bus.gf_y),       32'(f1_pts[0][9:0]));
        runTo(51);
        checkOutput("res0_pulse", 32'(bus.res_valid), 32'd0);
        checkOutput("no_filler_between", 32'(filler_cnt), 32'd1);
        checkOutput("f1_x1", 32'(bus.gf_x), 32'(f1_pts[1][19:10]));
        runTo(75);
        checkOutput("res1_valid",  32'(bus.res_valid),  32'd1);
        checkOutput("res1_inside", 32'(bus.res_inside), 32'd0);
        checkOutput("res1_tag",    32'(bus.res_tag),    32'd1);
        runTo(100);
        checkOutput("res2_valid",  32'(bus.res_valid),  32'd1);
        checkOutput("res2_inside", 32'(bus.res_inside), 32'd1);
        checkOutput("res2_tag",    32'(bus.res_tag),    32'd2);
        checkOutput("host_drained", 32'(host_q.size()), 32'd0);
        checkOutput("res_count",   32'(res_seen),       32'd3);
        checkOutput("stream_err",  32'(err),            32'd0);
        runTo(101);
        checkOutput("tail_filler", 32'(filler_cnt), 32'd2);

        // Empty stream: fillers only.
        $display("[TB] empty stream");
        doReset();
        runTo(100);
        checkOutput("empty_filler", 32'(filler_cnt), 32'd4);
        checkOutput("empty_res",    32'(res_seen),   32'd0);
        checkOutput("empty_gf",     32'(gf_nonzero), 32'd0);
        checkOutput("empty_err",    32'(err),        32'd0);

        // Silent engine: the wait times out and the next frame restarts at idx 0.
        $display("[TB] engine timeout");
        doReset();
        engine_on = 1'b0;
        pushFrame(10'd300, 10'd300);
        runTo(37);
        checkOutput("timeout_err_early", 32'(err), 32'd0);
        runTo(39);
        checkOutput("timeout_err", 32'(err), 32'd1);
        checkOutput("timeout_x0",  32'(bus.gf_x), 32'd300);
        checkOutput("timeout_y0",  32'(bus.gf_y), 32'd300);
        runTo(40);
        checkOutput("timeout_x1",  32'(bus.gf_x), 32'd200);
        engine_on = 1'b1;

        // Stray strobe during SEND idx 3.
        $display("[TB] strobe during send");
        doReset();
        pushFrame(10'd300, 10'd300);
        runTo(28);
        checkOutput("stray_err_before", 32'(err), 32'd0);
        inject = 1'b1;
        applyStimulus();
        inject = 1'b0;
        checkOutput("stray_err", 32'(err), 32'd1);
        checkOutput("stray_x4",  32'(bus.gf_x), 32'd400);
        checkOutput("stray_y4",  32'(bus.gf_y), 32'd300);
        runTo(31);
        checkOutput("stray_x6",  32'(bus.gf_x), 32'd250);
        checkOutput("stray_y6",  32'(bus.gf_y), 32'd387);
        runTo(50);
        checkOutput("stray_res_valid",  32'(bus.res_valid),  32'd1);
        checkOutput("stray_res_inside", 32'(bus.res_inside), 32'd1);
        checkOutput("stray_res_tag",    32'(bus.res_tag),    32'd0);

        // Asynchronous reset at SEND idx 4 with two frames buffered.
        $display("[TB] reset mid-frame");
        doReset();
        pushFrame(10'd300, 10'd300);
        pushFrame(10'd600, 10'd600);
        runTo(28);
        checkOutput("mid_ready_full", 32'(bus.in_ready), 32'd0);
        inject = 1'b1;
        applyStimulus();
        inject = 1'b0;
        checkOutput("mid_err_set", 32'(err), 32'd1);
        checkOutput("mid_x4",      32'(bus.gf_x), 32'd400);
        #2;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        host_q.delete();
        #1;
        checkResetValues("mid_reset");
        @(negedge clk);
        releaseReset();
        runTo(26);
        checkOutput("after_reset_filler", 32'(filler_cnt),   32'd2);
        checkOutput("after_reset_ready",  32'(bus.in_ready), 32'd1);
        runTo(27);
        checkOutput("after_reset_gf_x",   32'(bus.gf_x),     32'd0);
        checkOutput("after_reset_gf_y",   32'(bus.gf_y),     32'd0);
        runTo(55);
        checkOutput("after_reset_res",    32'(res_seen),     32'd0);
        checkOutput("after_reset_gf_any", 32'(gf_nonzero),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
